// File: rtl/ddc_cfg_pkg.sv
// Shared constants for the DDC configuration loader: default sizes,
// FSM state encoding and sticky error codes.
`timescale 1ns/1ps
package ddc_cfg_pkg;

  localparam int CONFIG_WIDTH = 32;
  localparam int TOTAL_WORDS  = 954;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ       = 3'd1;
  localparam logic [2:0] ST_STREAM    = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NO_ACK  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/ddc_cfg_buf.sv
// Coefficient buffer: simple dual-port RAM with one write port and one
// registered read port. Contents are deliberately not reset.
`timescale 1ns/1ps
module ddc_cfg_buf #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ddc_config_loader.sv
// Streams a host-loaded coefficient buffer to the downstream filter-chain
// controller after a request/ACK handshake, then waits for its completion.
`timescale 1ns/1ps
module ddc_config_loader #(
  parameter int CONFIG_WIDTH   = ddc_cfg_pkg::CONFIG_WIDTH,
  parameter int TOTAL_WORDS    = ddc_cfg_pkg::TOTAL_WORDS,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [CONFIG_WIDTH-1:0] wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err,
  output logic                    wr_reject,
  output logic                    isConfig,
  output logic [CONFIG_WIDTH-1:0] Data_Config_Out,
  input  logic                    isConfigACK,
  input  logic                    isConfigDone
);

  import ddc_cfg_pkg::*;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_WORDS - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]              state_reg, state_next;
  logic                    busy_reg, done_reg, wr_reject_reg;
  logic [1:0]              err_reg;
  logic [ADDR_WIDTH-1:0]   rd_addr_reg;
  logic                    rd_end_reg, out_valid_reg, out_last_reg, first_reg;
  logic                    done_seen_reg;
  logic [WAIT_W-1:0]       wait_cnt_reg;
  logic [CONFIG_WIDTH-1:0] rd_data;

  logic start_ok, no_ack, rd_issue, done_hit, timeout;

  assign start_ok = (state_reg == ST_IDLE) && start;
  // The ACK is only judged in the first STREAM cycle (R+1).
  assign no_ack   = (state_reg == ST_STREAM) && first_reg && !isConfigACK;
  assign rd_issue = (state_reg == ST_REQ) ||
                    ((state_reg == ST_STREAM) && !rd_end_reg && !no_ack);
  assign done_hit = done_seen_reg || isConfigDone;
  assign timeout  = (state_reg == ST_WAIT_DONE) && !done_hit && (wait_cnt_reg == WAIT_LAST);

  ddc_cfg_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (CONFIG_WIDTH)
  ) u_buf (
    .CLK     (CLK),
    .wr_en   (wr_en && !busy_reg),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr_reg),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start) state_next = ST_REQ;
      ST_REQ:       state_next = ST_STREAM;
      ST_STREAM: begin
        if (no_ack)            state_next = ST_FINISH;
        else if (out_last_reg) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (done_hit || timeout) state_next = ST_FINISH;
      ST_FINISH:    state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wr_reject_reg <= 1'b0;
      err_reg       <= ERR_OK;
      rd_addr_reg   <= '0;
      rd_end_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      first_reg     <= 1'b0;
      done_seen_reg <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= (state_next != ST_IDLE);
      done_reg      <= (state_reg == ST_WAIT_DONE) && done_hit;
      wr_reject_reg <= wr_en && busy_reg;
      out_valid_reg <= rd_issue;
      out_last_reg  <= rd_issue && (rd_addr_reg == LAST_ADDR);
      first_reg     <= (state_reg == ST_REQ);

      if (start_ok) begin
        err_reg       <= ERR_OK;
        done_seen_reg <= 1'b0;
        rd_addr_reg   <= '0;
        rd_end_reg    <= 1'b0;
        wait_cnt_reg  <= '0;
      end

      // Hold the address on the last word so it never wraps.
      if (rd_issue) begin
        if (rd_addr_reg == LAST_ADDR) rd_end_reg  <= 1'b1;
        else                          rd_addr_reg <= rd_addr_reg + 1'b1;
      end

      if (no_ack)  err_reg <= ERR_NO_ACK;
      if (timeout) err_reg <= ERR_TIMEOUT;

      if (((state_reg == ST_STREAM) || (state_reg == ST_WAIT_DONE)) && isConfigDone)
        done_seen_reg <= 1'b1;

      if ((state_reg == ST_WAIT_DONE) && !done_hit && !timeout)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign err             = err_reg;
  assign wr_reject       = wr_reject_reg;
  assign isConfig        = (state_reg == ST_REQ);
  assign Data_Config_Out = out_valid_reg ? rd_data : '0;

endmodule

// File: tb/tb_ddc_config_loader.sv
// Self-checking bench: per-cycle comparison of all outputs against a
// cycle-indexed reference derived from the buffer shadow and handshake rules.
`timescale 1ns/1ps
module tb_ddc_config_loader;

  localparam int T  = 954;
  localparam int TO = 4096;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          start;
  logic          busy, done, wr_reject, isConfig;
  logic [1:0]    err;
  logic [31:0]   Data_Config_Out;
  logic          isConfigACK, isConfigDone;

  logic [31:0] model_mem [0:(2**AW)-1];
  int checks = 0;
  int errors = 0;
  int dl = 0;

  always #5 CLK = ~CLK;

  ddc_config_loader #(
    .CONFIG_WIDTH   (32),
    .TOTAL_WORDS    (T),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .wr_reject       (wr_reject),
    .isConfig        (isConfig),
    .Data_Config_Out (Data_Config_Out),
    .isConfigACK     (isConfigACK),
    .isConfigDone    (isConfigDone)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] pack(input logic isc, input logic bsy, input logic dn,
                                       input logic rej, input logic [1:0] e, input logic [31:0] d);
    return {26'b0, isc, bsy, dn, rej, e, d};
  endfunction

  function automatic logic [63:0] observed();
    return pack(isConfig, busy, done, wr_reject, err, Data_Config_Out);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load_buf(input bit rand_data);
    for (int a = 0; a < T; a++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = rand_data ? $urandom : 32'(a + 32'h100);
      model_mem[a] = wr_data;
      tick();
    end
    wr_en = 1'b0;
    check("load_idle", observed(), pack(0, 0, 0, 0, err, 32'h0));
  endtask

  // One download. Cycle c=0 is the REQ cycle R; the reference outputs for
  // each cycle follow directly from the buffer shadow and the handshake plan.
  task automatic download(input bit ack, input int done_at, input int wr_at,
                          input int start_at, input int rst_at,
                          input bit pre_wr, input logic [31:0] pre_val);
    int fin;
    logic [31:0] exp_d;
    logic [1:0]  exp_e;
    dl++;
    if (!ack)             fin = 2;
    else if (done_at < 0) fin = T + 1 + TO;
    else                  fin = ((done_at > T + 1) ? done_at : T + 1) + 1;

    start = 1'b1;
    if (pre_wr) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = pre_val;
      model_mem[0] = pre_val;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;

    for (int c = 0; c <= fin + 2; c++) begin
      exp_d = (c >= 1 && c <= T && (ack || c == 1)) ? model_mem[c-1] : 32'h0;
      if (!ack)             exp_e = (c >= 2) ? 2'd1 : 2'd0;
      else if (done_at < 0) exp_e = (c >= fin) ? 2'd2 : 2'd0;
      else                  exp_e = 2'd0;
      check($sformatf("dl%0d_c%0d", dl, c), observed(),
            pack(c == 0, c <= fin, ack && done_at >= 0 && c == fin,
                 wr_at >= 0 && c == wr_at + 1, exp_e, exp_d));

      if (c == rst_at) begin
        nRST = 1'b0;
        #1;
        check($sformatf("dl%0d_rst", dl), observed(), pack(0, 0, 0, 0, 2'd0, 32'h0));
        nRST = 1'b1;
        isConfigACK = 1'b0; isConfigDone = 1'b0; wr_en = 1'b0; start = 1'b0;
        tick();
        check($sformatf("dl%0d_post_rst", dl), observed(), pack(0, 0, 0, 0, 2'd0, 32'h0));
        return;
      end

      isConfigACK  = ack && c >= 1 && c <= fin;
      isConfigDone = (c == done_at);
      start        = (c == start_at);
      wr_en        = (c == wr_at);
      wr_addr      = AW'(5);
      wr_data      = $urandom;
      tick();
    end
    isConfigACK = 1'b0; isConfigDone = 1'b0; start = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    isConfigACK = 1'b0; isConfigDone = 1'b0;
    repeat (3) tick();
    check("reset_outputs", observed(), pack(0, 0, 0, 0, 2'd0, 32'h0));
    nRST = 1'b1;
    tick();
    check("idle_after_reset", observed(), pack(0, 0, 0, 0, 2'd0, 32'h0));

    load_buf(1'b0);
    // Successful download, done pulsed somewhere inside the stream.
    download(1'b1, int'($urandom_range(T, 1)), -1, -1, -1, 1'b0, 32'h0);
    // Downstream never ACKs; a stray done pulse must be ignored.
    download(1'b0, int'($urandom_range(4, 1)), -1, -1, -1, 1'b0, 32'h0);
    // ACK but no completion: watchdog.
    download(1'b1, -1, -1, -1, -1, 1'b0, 32'h0);
    // Write to addr 5 and a second start during STREAM, done after the stream.
    download(1'b1, T + 1 + int'($urandom_range(50, 0)), 200, 400, -1, 1'b0, 32'h0);
    // Buffer[5] must be intact here.
    download(1'b1, int'($urandom_range(T + 10, 1)), -1, -1, -1, 1'b0, 32'h0);
    // Reset at word 300, then a clean download from buffer[0].
    download(1'b1, -1, -1, -1, 301, 1'b0, 32'h0);
    download(1'b1, int'($urandom_range(T, 1)), -1, -1, -1, 1'b0, 32'h0);

    load_buf(1'b1);
    // Write to addr 0 in the same cycle as start.
    download(1'b1, int'($urandom_range(T + 5, 1)), -1, -1, -1, 1'b1, 32'hDEAD0000 | 32'($urandom_range(16'hFFFF, 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ddc_config_loader.md
DDC_CONFIG_LOADER -- requirements
Module: ddc_config_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 32: config word width.
REQ-002 SHALL have parameter TOTAL_WORDS, default 954: number of words streamed per configuration (CIC/CICC, MHBF and DFIR sets back to back).
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: buffer address width; TOTAL_WORDS <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit for WAIT_DONE.
REQ-005 CLK  input  1  clock; all logic on the rising edge.
REQ-006 nRST  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  host write strobe to the coefficient buffer.
REQ-008 wr_addr  input  ADDR_WIDTH  host write address.
REQ-009 wr_data  input  CONFIG_WIDTH  host write data.
REQ-010 start  input  1  request one configuration download.
REQ-011 busy  output  1  high from the cycle after start is accepted until the cycle after the return to IDLE.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 err  output  2  sticky status: 0 ok, 1 no ACK, 2 done timeout; cleared on the next accepted start.
REQ-014 wr_reject  output  1  one-cycle pulse when wr_en arrives while busy.
REQ-015 isConfig  output  1  one-cycle configuration request to the downstream filter-chain controller.
REQ-016 Data_Config_Out  output  CONFIG_WIDTH  streamed config word.
REQ-017 isConfigACK  input  1  downstream acknowledge, registered level.
REQ-018 isConfigDone  input  1  downstream completion pulse.

Function
REQ-019 SHALL hold states IDLE, REQ, STREAM, WAIT_DONE, FINISH.
REQ-020 SHALL write wr_data to buffer[wr_addr] on wr_en only when busy is low; when busy is high, the write SHALL be dropped and wr_reject pulsed.
REQ-021 IDLE: start=1 SHALL move to REQ and clear err; a write in the same cycle SHALL land before the first read.
REQ-022 REQ, cycle R: SHALL assert isConfig for exactly cycle R, issue buffer read of address 0, and go to STREAM.
REQ-023 Buffer read SHALL have 1-cycle latency; Data_Config_Out SHALL equal buffer[k] in cycle R+1+k for k = 0..TOTAL_WORDS-1, with one word per cycle and no stalls.
REQ-024 Data_Config_Out SHALL be 0 in every cycle outside the window in REQ-023.
REQ-025 In cycle R+1, isConfigACK=0 SHALL set err=1, force Data_Config_Out to 0 and go to FINISH without done.
REQ-026 After word TOTAL_WORDS-1, STREAM SHALL go to WAIT_DONE.
REQ-027 isConfigDone SHALL be monitored from cycle R+1 onward. Completion SHALL be signalled only if isConfigDone has been seen and the stream has finished. In that case done SHALL pulse in FINISH.
REQ-028 WAIT_DONE SHALL count cycles; reaching TIMEOUT_CYCLES without isConfigDone SHALL set err=2 and go to FINISH without done.
REQ-029 FINISH SHALL last one cycle, then return to IDLE.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Read address counter SHALL be ADDR_WIDTH bits and SHALL not wrap within a download.

Reset
REQ-032 On nRST low, SHALL go to IDLE with busy, done, wr_reject, isConfig = 0, err = 0, Data_Config_Out = 0 and counters = 0.
REQ-033 Buffer contents SHALL NOT be reset. Reset during a download SHALL abort it without pulsing done.

Structure
REQ-034 Shared package ddc_cfg_pkg SHALL hold CONFIG_WIDTH, TOTAL_WORDS, the state encoding and the err codes.
REQ-035 The buffer SHALL be the sub-module ddc_cfg_buf: simple dual-port RAM, 2**ADDR_WIDTH x CONFIG_WIDTH, with registered read.

Verification
REQ-036 Load buffer[k]=k+0x100; start with a downstream model that ACKs at R+1 and pulses Done -> Data_Config_Out = 0x100..0x100+953 on consecutive cycles from R+1, then one done pulse, err=0.
REQ-037 Model never ACKs -> err=1, no done, Data_Config_Out=0 from R+2, busy drops.
REQ-038 ACK given but Done withheld -> err=2 exactly TIMEOUT_CYCLES into WAIT_DONE, no done.
REQ-039 wr_en to addr 5 during STREAM -> wr_reject pulses and buffer[5] is unchanged on the next download; start during STREAM is ignored.
REQ-040 nRST pulsed mid-STREAM at word 300 -> all outputs 0 immediately; a new start streams from buffer[0] with contents intact.
REQ-041 wr_en to addr 0 and start in the same cycle -> first streamed word equals the new data.
